ln_stats_accum: RTL and testbench

- Upstream statistics stage of the LayerNorm datapath.
- Consumes one element per accepted beat over an N-element vector and accumulates the sum and the sum of squares.
- Produces the vector mean (S1.4.11) and variance (UQ5.11); the variance feeds the PWL rsqrt stage directly.
- Global `i_en` stall semantics: every register holds while `i_en`=0.

---
 rtl/ln_stats_accum.sv | 190 +++++++++++++++++++
 tb/tb_ln_stats_accum.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln_stats_accum.sv
// -----------------------------------------------------------------------------
// ln_stats_accum
//
// Statistics stage of the LayerNorm datapath. It accumulates sum and sum of
// squares over an N = 2**LOG2_N element vector, one element per accepted beat.
// It then produces the vector mean (signed S1.4.11) and the variance
// (unsigned UQ5.11, saturated). The variance feeds the PWL rsqrt stage.
//
// Optional build macro: LN_STATS_EPS_EN
//   When defined, EPS (in UQ5.11 LSBs) is added to the variance before
//   saturation, so o_var >= EPS. When undefined, EPS is ignored.
//
// Handshake: an element is consumed on a rising edge where
// i_en & i_valid & o_ready is true. When i_valid is high while o_ready is low,
// the element is not consumed and the producer must hold it.
// o_valid is a one-enabled-cycle pulse. The consumer qualifies it with i_en.
// Every register holds while i_en = 0.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_en     global clock enable (0 freezes all state and outputs)
//   i_clear  synchronous abort of the current vector (qualified by i_en)
//   i_valid  i_data valid
//   i_data   element, signed S1.4.11
//   o_ready  block accepts an element this cycle
//   o_valid  result valid (registered)
//   o_mean   mean, signed S1.4.11
//   o_var    variance, unsigned UQ5.11, saturated
// -----------------------------------------------------------------------------
module ln_stats_accum #(
    parameter int LOG2_N = 6,
    parameter int EPS    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_valid,
    output logic [15:0] o_mean,
    output logic [15:0] o_var
);

    localparam int SW = 16 + LOG2_N;   // signed sum width
    localparam int QW = 31 + LOG2_N;   // unsigned sum-of-squares width

`ifdef LN_STATS_EPS_EN
    localparam int EPS_ADD = EPS;
`else
    // Without the macro the epsilon term contributes nothing.
    localparam int EPS_ADD = EPS * 0;
`endif

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_MEAN = 2'd1,
        S_SQ   = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LOG2_N-1:0]  r_cnt;
    logic signed [SW-1:0] r_sum;
    logic [QW-1:0]      r_sumsq;
    logic signed [15:0] r_mean;
    logic [30:0]        r_ex2;
    logic [30:0]        r_msq;
    logic               r_valid;
    logic [15:0]        r_mean_out;
    logic [15:0]        r_var;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic signed [31:0]   w_sq;
    logic signed [SW-1:0] w_mean_full;
    logic [QW-1:0]        w_ex2_full;
    logic signed [31:0]   w_msq_full;
    logic signed [31:0]   w_diff;
    logic [30:0]          w_dpos;
    logic [20:0]          w_v;
    logic [15:0]          w_var_sat;
    logic                 w_unused_bits;

    // A square of S1.4.11 is at most 2**30, so 31 unsigned bits hold it.
    assign w_sq        = $signed(i_data) * $signed(i_data);
    assign w_mean_full = r_sum >>> LOG2_N;
    assign w_ex2_full  = r_sumsq >> LOG2_N;
    assign w_msq_full  = r_mean * r_mean;

    // E[x^2] - mean^2 can go slightly negative because both terms are floored.
    // Clamp it to zero.
    assign w_diff    = $signed({1'b0, r_ex2}) - $signed({1'b0, r_msq});
    assign w_dpos    = w_diff[31] ? 31'd0 : w_diff[30:0];
    assign w_v       = {1'b0, w_dpos[30:11]} + 21'(EPS_ADD);
    assign w_var_sat = (|w_v[20:16]) ? 16'hFFFF : w_v[15:0];

    // The mean and E[x^2] always fit the narrow registers. The dropped bits
    // are redundant sign bits or are below Q.11 resolution.
    assign w_unused_bits = ^{w_sq[31], w_mean_full[SW-1:16], w_ex2_full[QW-1:31],
                             w_msq_full[31], w_dpos[10:0]};

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_ACC;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = S_ACC;
        end else begin
            case (r_state)
                S_ACC:   if (i_valid && (r_cnt == '1)) w_state_nxt = S_MEAN;
                S_MEAN:  w_state_nxt = S_SQ;
                S_SQ:    w_state_nxt = S_OUT;
                S_OUT:   w_state_nxt = S_ACC;
                default: w_state_nxt = S_ACC;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_sum      <= '0;
            r_sumsq    <= '0;
            r_mean     <= '0;
            r_ex2      <= '0;
            r_msq      <= '0;
            r_valid    <= 1'b0;
            r_mean_out <= '0;
            r_var      <= '0;
        end else if (i_en) begin
            r_valid <= 1'b0;
            if (i_clear) begin
                // Clear takes priority over a coincident accept.
                // The published results are kept.
                r_cnt   <= '0;
                r_sum   <= '0;
                r_sumsq <= '0;
            end else begin
                case (r_state)
                    S_ACC: begin
                        if (i_valid) begin
                            r_cnt   <= r_cnt + LOG2_N'(1);   // wraps to 0 after N-1
                            r_sum   <= r_sum + {{LOG2_N{i_data[15]}}, i_data};
                            r_sumsq <= r_sumsq + {{LOG2_N{1'b0}}, w_sq[30:0]};
                        end
                    end
                    S_MEAN: begin
                        r_mean  <= w_mean_full[15:0];
                        r_ex2   <= w_ex2_full[30:0];
                        r_sum   <= '0;
                        r_sumsq <= '0;
                    end
                    S_SQ: begin
                        r_msq <= w_msq_full[30:0];
                    end
                    S_OUT: begin
                        r_valid    <= 1'b1;
                        r_mean_out <= r_mean;
                        r_var      <= w_var_sat;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ready = (r_state == S_ACC);
    assign o_valid = r_valid;
    assign o_mean  = r_mean_out;
    assign o_var   = r_var;

endmodule

// File: tb/tb_ln_stats_accum.sv
// -----------------------------------------------------------------------------
// tb_ln_stats_accum
//
// Directed bench for ln_stats_accum with LOG2_N = 2 (4-element vectors).
// The expected mean and variance values are worked out by hand from the
// fixed-point definitions.
// -----------------------------------------------------------------------------
module tb_ln_stats_accum;

    localparam int LOG2_N = 2;
    localparam int EPS    = 1;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_clear;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_mean;
    logic [15:0] o_var;

    ln_stats_accum #(.LOG2_N(LOG2_N), .EPS(EPS)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_mean  (o_mean),
        .o_var   (o_var)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];   // {mean, var}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    endtask

    // Variance as seen at the output, including the optional epsilon term.
    function automatic logic [15:0] fix_var(input logic [15:0] v);
`ifdef LN_STATS_EPS_EN
        logic [16:0] t;
        t = {1'b0, v} + 17'(EPS);
        return t[16] ? 16'hFFFF : t[15:0];
`else
        return v;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one element and hold it until it is accepted.
    task automatic send(input logic [15:0] d);
        int b;
        b = 0;
        i_valid = 1'b1;
        i_data  = d;
        while (!(o_ready && i_en) && b < 40) begin
            step();
            b++;
        end
        if (b >= 40) check("send_timeout", 32'(b), 32'd0);
        step();
        i_valid = 1'b0;
        i_data  = 16'h0;
    endtask

    // Call this directly after the last element is sent.
    task automatic expect_result(input string name, input logic [15:0] m, input logic [15:0] v);
        int lat;
        lat = 0;
        while (!o_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_mean"}, {16'h0, o_mean}, {16'h0, m});
        check({name, "_var"}, {16'h0, o_var}, {16'h0, v});
        step();
        check({name, "_valid_drop"}, {31'h0, o_valid}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0][15:0] d;
        logic [15:0]      mean;
        logic [15:0]      vr;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] e,
                                input logic [15:0] m, input logic [15:0] v);
        vec_t t;
        t.d[0] = a; t.d[1] = b; t.d[2] = c; t.d[3] = e;
        t.mean = m; t.vr = v;
        return t;
    endfunction

    vec_t tbl [5];

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] bb [8];
        logic [31:0] exp_r;
        int idx, gap, got, cyc;
        bit seen;

        tbl[0] = mk(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000);
        tbl[1] = mk(16'h0800, 16'hF800, 16'h0800, 16'hF800, 16'h0000, 16'h0800);
        tbl[2] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF);
        tbl[3] = mk(16'h0400, 16'h0C00, 16'h0400, 16'h0C00, 16'h0800, 16'h0200);
        tbl[4] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);

        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_data  = 16'h0;
        step();
        step();
        check("rst_valid", {31'h0, o_valid}, 32'd0);
        check("rst_mean", {16'h0, o_mean}, 32'd0);
        check("rst_var", {16'h0, o_var}, 32'd0);
        i_rst_n = 1'b1;
        step();
        check("rst_ready", {31'h0, o_ready}, 32'd1);

        // Table-driven vectors.
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) send(tbl[k].d[j]);
            expect_result($sformatf("vec%0d", k), tbl[k].mean, fix_var(tbl[k].vr));
        end

        // Stall: i_en low for 5 cycles after the 2nd element, then a stall on the pulse.
        send(16'h0800);
        send(16'hF800);
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0];
            i_data  = 16'h1234;
            step();
        end
        i_valid = 1'b0;
        i_en    = 1'b1;
        send(16'h0800);
        send(16'hF800);
        step();
        step();
        check("stall_pre_valid", {31'h0, o_valid}, 32'd0);
        step();
        check("stall_valid", {31'h0, o_valid}, 32'd1);
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid_hold", {31'h0, o_valid}, 32'd1);
        end
        check("stall_mean", {16'h0, o_mean}, 32'h0000);
        check("stall_var", {16'h0, o_var}, {16'h0, fix_var(16'h0800)});
        i_en = 1'b1;
        step();
        check("stall_valid_drop", {31'h0, o_valid}, 32'd0);

        // Async reset mid-vector.
        send(16'h0800);
        send(16'h0800);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, o_valid}, 32'd0);
        check("mid_rst_mean", {16'h0, o_mean}, 32'd0);
        step();
        i_rst_n = 1'b1;
        step();
        for (int j = 0; j < 4; j++) send(16'h1000);
        expect_result("post_rst", 16'h1000, fix_var(16'h0000));

        // Back-to-back vectors with i_valid held high.
        bb = '{16'h0800, 16'hF800, 16'h0800, 16'hF800,
               16'h0800, 16'h0800, 16'h0800, 16'h0800};
        exp_q.push_back({16'h0000, fix_var(16'h0800)});
        exp_q.push_back({16'h0800, fix_var(16'h0000)});
        idx = 0; gap = 0; got = 0; cyc = 0;
        while (got < 2 && cyc < 60) begin
            logic rdy;
            i_valid = (idx < 8);
            i_data  = (idx < 8) ? bb[idx] : 16'h0;
            rdy = o_ready;
            step();
            cyc++;
            if (rdy && idx < 8) idx++;
            else if (!rdy && idx == 4) gap++;
            if (o_valid) begin
                got++;
                if (exp_q.size() > 0) begin
                    exp_r = exp_q.pop_front();
                    check("b2b_mean", {16'h0, o_mean}, {16'h0, exp_r[31:16]});
                    check("b2b_var", {16'h0, o_var}, {16'h0, exp_r[15:0]});
                end
            end
        end
        i_valid = 1'b0;
        check("b2b_results", 32'(got), 32'd2);
        check("b2b_gap", 32'(gap), 32'd3);

        // Clear in S_SQ: no pulse, outputs kept.
        for (int j = 0; j < 4; j++) send(tbl[3].d[j]);
        step();                       // now in S_SQ
        check("clr_sq_ready", {31'h0, o_ready}, 32'd0);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clr_sq_ready_back", {31'h0, o_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (o_valid) seen = 1'b1;
            step();
        end
        check("clr_sq_no_valid", {31'h0, seen}, 32'd0);
        check("clr_sq_mean_kept", {16'h0, o_mean}, 32'h0800);
        check("clr_sq_var_kept", {16'h0, o_var}, {16'h0, fix_var(16'h0000)});

        // Clear in S_ACC, coincident with a valid element: the element is discarded.
        send(16'h7FFF);
        send(16'h7FFF);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h7FFF;
        step();
        i_clear = 1'b0;
        i_valid = 1'b0;
        for (int j = 0; j < 4; j++) send(tbl[3].d[j]);
        expect_result("clr_acc", 16'h0800, fix_var(16'h0200));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
